// File: rtl/seg_pkg.sv
// Shared constants for the pipeline segment registers: default bundle widths,
// control-bit positions, per-boundary kill masks and the occupancy update rule.
package seg_pkg;

    localparam int DATA_W_MWB      = 69;
    localparam int CTRL_W_MWB      = 2;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;

    localparam logic [CTRL_W_MWB-1:0] KILL_MWB = 2'b01;
    localparam logic [CTRL_W_MWB-1:0] KILL_EXM = 2'b11;

    localparam int OCC_W      = 3;
    localparam int STAGES_MAX = 4;

    // One entry in and one out on the same edge leaves the count unchanged.
    function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] occ,
                                                   input logic            enter,
                                                   input logic            leave);
        logic [OCC_W-1:0] nxt;
        nxt = occ;
        case ({enter, leave})
            2'b10:   nxt = occ + 3'd1;
            2'b01:   nxt = occ - 3'd1;
            default: nxt = occ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seg_pipe_cell.sv
// One pipeline slot: valid bit, control bundle and data bundle with
// flush > stall > load priority.
module seg_pipe_cell
    import seg_pkg::*;
#(
    parameter int                DATA_W         = 96,
    parameter int                CTRL_W         = 2,
    parameter logic [CTRL_W-1:0] KILL_MASK      = {CTRL_W{1'b1}},
    parameter bit                FLUSH_CLR_DATA = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_ctrl  <= '0;
            o_data  <= '0;
        end else if (i_flush) begin
            // Non-kill control bits survive a flush so side-band state is not lost.
            o_valid <= 1'b0;
            o_ctrl  <= o_ctrl & ~KILL_MASK;
            if (FLUSH_CLR_DATA)
                o_data <= '0;
        end else if (!i_stall) begin
            o_valid <= i_valid;
            o_ctrl  <= i_ctrl;
            o_data  <= i_data;
        end
    end

endmodule

// File: rtl/seg_pipe_reg.sv
// Generic pipeline segment register: STAGES chained slots with stall, flush,
// input control gating and a registered occupancy count.
module seg_pipe_reg
    import seg_pkg::*;
#(
    parameter int                DATA_W         = 96,
    parameter int                CTRL_W         = 2,
    parameter int                STAGES         = 1,
    parameter logic [CTRL_W-1:0] KILL_MASK      = {CTRL_W{1'b1}},
    parameter bit                FLUSH_CLR_DATA = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [OCC_W-1:0]  o_occupancy
);

    logic [STAGES:0]             chain_valid;
    logic [STAGES:0][CTRL_W-1:0] chain_ctrl;
    logic [STAGES:0][DATA_W-1:0] chain_data;
    logic [OCC_W-1:0]            occ;

    // An invalid entry must never carry an active kill-masked control bit downstream.
    assign chain_valid[0] = i_valid;
    assign chain_ctrl[0]  = i_valid ? i_ctrl : (i_ctrl & ~KILL_MASK);
    assign chain_data[0]  = i_data;

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        seg_pipe_cell #(
            .DATA_W         (DATA_W),
            .CTRL_W         (CTRL_W),
            .KILL_MASK      (KILL_MASK),
            .FLUSH_CLR_DATA (FLUSH_CLR_DATA)
        ) u_cell (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_flush (i_flush),
            .i_stall (i_stall),
            .i_valid (chain_valid[g]),
            .i_ctrl  (chain_ctrl[g]),
            .i_data  (chain_data[g]),
            .o_valid (chain_valid[g+1]),
            .o_ctrl  (chain_ctrl[g+1]),
            .o_data  (chain_data[g+1])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            occ <= '0;
        else if (i_flush)
            occ <= '0;
        else if (!i_stall)
            occ <= occ_step(occ, i_valid, chain_valid[STAGES]);
    end

    assign o_valid     = chain_valid[STAGES];
    assign o_ctrl      = chain_valid[STAGES] ? chain_ctrl[STAGES]
                                             : (chain_ctrl[STAGES] & ~KILL_MASK);
    assign o_data      = chain_data[STAGES];
    assign o_occupancy = occ;

endmodule

// File: tb/tb_seg_pipe_reg.sv
// Self-checking bench: four differently configured instances share one stimulus
// stream and are compared against a slot-array reference model.
module tb_seg_pipe_reg;

    localparam int NI = 4;
    localparam logic [3:0][2:0] ST_P   = {3'd4, 3'd3, 3'd1, 3'd2};
    localparam logic [3:0][1:0] KILL_P = {2'b10, 2'b11, 2'b01, 2'b01};
    localparam logic [3:0]      FCD_P  = 4'b1010;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [1:0]  i_ctrl  = '0;
    logic [31:0] i_data  = '0;

    logic [3:0]       dv;
    logic [3:0][1:0]  dc;
    logic [3:0][31:0] dd;
    logic [3:0][2:0]  doc;

    int n_checks = 0;
    int n_errors = 0;

    logic        m_valid [NI][4];
    logic [1:0]  m_ctrl  [NI][4];
    logic [31:0] m_data  [NI][4];

    always #5 i_clk = ~i_clk;

    seg_pipe_reg #(.DATA_W(32), .CTRL_W(2), .STAGES(2), .KILL_MASK(2'b01), .FLUSH_CLR_DATA(1'b0)) u0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(dv[0]), .o_ctrl(dc[0]), .o_data(dd[0]),
        .o_occupancy(doc[0]));
    seg_pipe_reg #(.DATA_W(32), .CTRL_W(2), .STAGES(1), .KILL_MASK(2'b01), .FLUSH_CLR_DATA(1'b1)) u1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(dv[1]), .o_ctrl(dc[1]), .o_data(dd[1]),
        .o_occupancy(doc[1]));
    seg_pipe_reg #(.DATA_W(32), .CTRL_W(2), .STAGES(3), .KILL_MASK(2'b11), .FLUSH_CLR_DATA(1'b0)) u2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(dv[2]), .o_ctrl(dc[2]), .o_data(dd[2]),
        .o_occupancy(doc[2]));
    seg_pipe_reg #(.DATA_W(32), .CTRL_W(2), .STAGES(4), .KILL_MASK(2'b10), .FLUSH_CLR_DATA(1'b1)) u3 (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(dv[3]), .o_ctrl(dc[3]), .o_data(dd[3]),
        .o_occupancy(doc[3]));

    task automatic model_reset();
        for (int n = 0; n < NI; n++)
            for (int k = 0; k < 4; k++) begin
                m_valid[n][k] = 1'b0;
                m_ctrl[n][k]  = '0;
                m_data[n][k]  = '0;
            end
    endtask

    // Slot 0 is the input side; entries move one slot per unstalled edge.
    task automatic model_step();
        for (int n = 0; n < NI; n++) begin
            if (i_flush) begin
                for (int k = 0; k < int'(ST_P[n]); k++) begin
                    m_valid[n][k] = 1'b0;
                    m_ctrl[n][k]  = m_ctrl[n][k] & ~KILL_P[n];
                    if (FCD_P[n]) m_data[n][k] = '0;
                end
            end else if (!i_stall) begin
                for (int k = int'(ST_P[n]) - 1; k > 0; k--) begin
                    m_valid[n][k] = m_valid[n][k-1];
                    m_ctrl[n][k]  = m_ctrl[n][k-1];
                    m_data[n][k]  = m_data[n][k-1];
                end
                m_valid[n][0] = i_valid;
                m_ctrl[n][0]  = i_valid ? i_ctrl : (i_ctrl & ~KILL_P[n]);
                m_data[n][0]  = i_data;
            end
        end
    endtask

    function automatic logic [37:0] exp_out(int n);
        int cnt = 0;
        int last = int'(ST_P[n]) - 1;
        logic [1:0] c;
        for (int k = 0; k < int'(ST_P[n]); k++)
            if (m_valid[n][k]) cnt++;
        c = m_valid[n][last] ? m_ctrl[n][last] : (m_ctrl[n][last] & ~KILL_P[n]);
        return {m_valid[n][last], c, m_data[n][last], 3'(cnt)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_valid = 1'b1; i_ctrl = 2'b11; i_data = 32'hFFFF_FFFF;
        model_reset();
        #2;
        for (int n = 0; n < NI; n++) begin
            n_checks++;
            if ({dv[n], dc[n], dd[n], doc[n]} !== 38'h0) begin
                n_errors++;
                $display("FAIL reset_initial u%0d: got %h want 0", n, {dv[n], dc[n], dd[n], doc[n]});
            end
        end
        repeat (2) @(posedge i_clk);
        #1;
        for (int n = 0; n < NI; n++) begin
            n_checks++;
            if ({dv[n], dc[n], dd[n], doc[n]} !== 38'h0) begin
                n_errors++;
                $display("FAIL reset_held u%0d: got %h want 0", n, {dv[n], dc[n], dd[n], doc[n]});
            end
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        i_valid = 1'b0; i_ctrl = '0; i_data = '0;
    endtask

    task automatic test_latency();
        logic [37:0] want [4];
        want[0] = {1'b0, 2'b00, 32'h0, 3'd1};
        want[1] = {1'b1, 2'b11, 32'hDEAD_BEEF, 3'd2};
        want[2] = {1'b1, 2'b01, 32'h0000_1234, 3'd1};
        want[3] = {1'b0, 2'b00, 32'h0, 3'd0};
        for (int c = 0; c < 4; c++) begin
            i_valid = (c < 2);
            i_ctrl  = (c == 0) ? 2'b11 : (c == 1) ? 2'b01 : 2'b00;
            i_data  = (c == 0) ? 32'hDEAD_BEEF : (c == 1) ? 32'h0000_1234 : 32'h0;
            tick();
            n_checks++;
            if ({dv[0], dc[0], dd[0], doc[0]} !== want[c]) begin
                n_errors++;
                $display("FAIL latency_u0 cycle%0d: got %h want %h", c, {dv[0], dc[0], dd[0], doc[0]}, want[c]);
            end
            for (int n = 0; n < NI; n++) begin
                n_checks++;
                if ({dv[n], dc[n], dd[n], doc[n]} !== exp_out(n)) begin
                    n_errors++;
                    $display("FAIL latency u%0d: got %h want %h", n, {dv[n], dc[n], dd[n], doc[n]}, exp_out(n));
                end
            end
        end
    endtask

    task automatic test_stall();
        i_valid = 1'b1; i_ctrl = 2'b01; i_data = 32'h11;
        tick();
        i_stall = 1'b1; i_data = 32'h22;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (dd[1] !== 32'h11 || dv[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold_u1 cycle%0d: got v=%b d=%h want v=1 d=11", c, dv[1], dd[1]);
            end
            for (int n = 0; n < NI; n++) begin
                n_checks++;
                if ({dv[n], dc[n], dd[n], doc[n]} !== exp_out(n)) begin
                    n_errors++;
                    $display("FAIL stall u%0d: got %h want %h", n, {dv[n], dc[n], dd[n], doc[n]}, exp_out(n));
                end
            end
        end
        i_stall = 1'b0;
        tick();
        n_checks++;
        if (dd[1] !== 32'h22) begin
            n_errors++;
            $display("FAIL stall_release_u1: got %h want 22", dd[1]);
        end
        i_valid = 1'b0; i_ctrl = '0; i_data = '0;
    endtask

    task automatic test_flush();
        i_valid = 1'b1; i_ctrl = 2'b11; i_data = 32'h55;
        tick();
        i_valid = 1'b0; i_ctrl = 2'b00; i_data = 32'h0;
        tick();
        n_checks++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'h55) begin
            n_errors++;
            $display("FAIL flush_preload_u0: got v=%b d=%h want v=1 d=55", dv[0], dd[0]);
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++;
        if ({dv[0], dc[0], dd[0], doc[0]} !== {1'b0, 2'b10, 32'h55, 3'd0}) begin
            n_errors++;
            $display("FAIL flush_u0: got %h want %h", {dv[0], dc[0], dd[0], doc[0]}, {1'b0, 2'b10, 32'h55, 3'd0});
        end
        for (int n = 0; n < NI; n++) begin
            n_checks++;
            if ({dv[n], dc[n], dd[n], doc[n]} !== exp_out(n)) begin
                n_errors++;
                $display("FAIL flush u%0d: got %h want %h", n, {dv[n], dc[n], dd[n], doc[n]}, exp_out(n));
            end
        end
    endtask

    task automatic test_flush_stall();
        for (int c = 0; c < 4; c++) begin
            i_valid = 1'b1; i_ctrl = 2'b11; i_data = $urandom;
            tick();
        end
        i_flush = 1'b1; i_stall = 1'b1; i_valid = 1'b1; i_ctrl = 2'b11; i_data = 32'hCAFE_F00D;
        tick();
        i_flush = 1'b0; i_stall = 1'b0; i_valid = 1'b0; i_ctrl = '0;
        for (int n = 0; n < NI; n++) begin
            n_checks++;
            if (dv[n] !== 1'b0 || doc[n] !== 3'd0 || (dc[n] & KILL_P[n]) !== 2'b00) begin
                n_errors++;
                $display("FAIL flush_stall u%0d: got v=%b occ=%0d ctrl=%b want v=0 occ=0 killbits=0",
                         n, dv[n], doc[n], dc[n]);
            end
            n_checks++;
            if ({dv[n], dc[n], dd[n], doc[n]} !== exp_out(n)) begin
                n_errors++;
                $display("FAIL flush_stall_model u%0d: got %h want %h", n, {dv[n], dc[n], dd[n], doc[n]}, exp_out(n));
            end
        end
    endtask

    task automatic test_invalid_input();
        i_valid = 1'b0; i_ctrl = 2'b11; i_data = 32'hA5A5_A5A5;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (dv[0] !== 1'b0 || dc[0] !== 2'b10) begin
                    n_errors++;
                    $display("FAIL invalid_gate_u0: got v=%b ctrl=%b want v=0 ctrl=10", dv[0], dc[0]);
                end
            end
            for (int n = 0; n < NI; n++) begin
                n_checks++;
                if ({dv[n], dc[n], dd[n], doc[n]} !== exp_out(n)) begin
                    n_errors++;
                    $display("FAIL invalid u%0d: got %h want %h", n, {dv[n], dc[n], dd[n], doc[n]}, exp_out(n));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            i_valid = 1'b1; i_ctrl = 2'($urandom); i_data = $urandom;
            tick();
        end
        n_checks++;
        if (doc[2] !== 3'd3 || doc[3] !== 3'd4) begin
            n_errors++;
            $display("FAIL full_occupancy: got u2=%0d u3=%0d want u2=3 u3=4", doc[2], doc[3]);
        end
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        for (int n = 0; n < NI; n++) begin
            n_checks++;
            if ({dv[n], dc[n], dd[n], doc[n]} !== 38'h0) begin
                n_errors++;
                $display("FAIL async_reset u%0d: got %h want 0", n, {dv[n], dc[n], dd[n], doc[n]});
            end
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        i_valid = 1'b1; i_ctrl = 2'b10; i_data = 32'h77;
        tick();
        n_checks++;
        if ({dv[1], dc[1], dd[1], doc[1]} !== {1'b1, 2'b10, 32'h77, 3'd1}) begin
            n_errors++;
            $display("FAIL first_capture_u1: got %h want %h", {dv[1], dc[1], dd[1], doc[1]}, {1'b1, 2'b10, 32'h77, 3'd1});
        end
        i_valid = 1'b0; i_ctrl = '0; i_data = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_stall = ($urandom_range(0, 5) == 0);
            i_flush = ($urandom_range(0, 11) == 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ctrl  = 2'($urandom);
            i_data  = $urandom;
            tick();
            for (int n = 0; n < NI; n++) begin
                n_checks++;
                if ({dv[n], dc[n], dd[n], doc[n]} !== exp_out(n)) begin
                    n_errors++;
                    $display("FAIL random c%0d u%0d: got %h want %h", c, n, {dv[n], dc[n], dd[n], doc[n]}, exp_out(n));
                end
                n_checks++;
                if (doc[n] > ST_P[n]) begin
                    n_errors++;
                    $display("FAIL occ_bound c%0d u%0d: got %0d want <= %0d", c, n, doc[n], ST_P[n]);
                end
            end
        end
        i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_flush_stall();
        test_invalid_input();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
